key_event_encoder: RTL and testbench

KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

---
 rtl/key_pkg.sv | 14 +
 rtl/key_fifo.sv | 55 +++++
 rtl/key_event_encoder.sv | 119 +++++++++++
 tb/tb_key_event_encoder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and the key-index width helper for the keypad event encoder.
package key_pkg;

  localparam int DEF_N            = 5;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_REPEAT_DELAY = 250;
  localparam int DEF_REPEAT_RATE  = 50;

  // Bits needed to hold a key index 0 .. n_keys-1 (at least one bit).
  function automatic int key_width(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Show-ahead event queue: head entry visible on o_data whenever o_empty is low.
module key_fifo
  import key_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full queue still takes a push when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Keypad press-event encoder: rising edges become pending events, queued lowest index first.
// Auto-repeat of a single held key is built only when KEY_REPEAT_EN is defined.
module key_event_encoder
  import key_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  localparam int NK    = N * N,
  localparam int KEY_W = key_width(N * N),
  localparam int CW    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk_500hz,
  input  logic             rst,
  input  logic [NK-1:0]    isPressed,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             any_pressed,
  output logic             overflow
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("key_event_encoder: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_repeat
    $error("key_event_encoder: REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  logic [NK-1:0]    r_prev;
  logic [NK-1:0]    r_pending;
  logic             r_overflow;
  logic [NK-1:0]    w_rise;
  logic [NK-1:0]    w_repeat_hit;
  logic [NK-1:0]    w_new;
  logic [NK-1:0]    w_push_mask;
  logic [KEY_W-1:0] w_push_code;
  logic [KEY_W-1:0] w_fifo_data;
  logic [CW-1:0]    w_count;
  logic             w_found;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_rise = isPressed & ~r_prev;
  assign w_new  = w_rise | w_repeat_hit;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    w_found     = 1'b0;
    w_push_code = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_found     = 1'b1;
        w_push_code = KEY_W'(i);
      end
    end
  end

  assign w_pop       = key_valid && key_ready;
  assign w_push      = w_found && (!w_full || w_pop);
  assign w_push_mask = w_push ? (NK'(1) << w_push_code) : '0;

  always_ff @(posedge clk_500hz) begin
    if (rst) begin
      r_prev     <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev    <= isPressed;
      r_pending <= (r_pending | w_new) & ~w_push_mask;
      if (|(w_new & r_pending)) r_overflow <= 1'b1;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] r_rpt_cnt;
  logic          w_single_hold;

  // Down-counter reloads on any change or when not exactly one key is held.
  assign w_single_hold = $onehot(isPressed) && (isPressed == r_prev);
  assign w_repeat_hit  = (w_single_hold && (r_rpt_cnt == '0)) ? isPressed : '0;

  always_ff @(posedge clk_500hz) begin
    if (rst)                   r_rpt_cnt <= '0;
    else if (!w_single_hold)   r_rpt_cnt <= RW'(REPEAT_DELAY - 1);
    else if (r_rpt_cnt == '0)  r_rpt_cnt <= RW'(REPEAT_RATE - 1);
    else                       r_rpt_cnt <= r_rpt_cnt - 1'b1;
  end
`else
  assign w_repeat_hit = '0;
`endif

  key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_500hz),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (w_push_code),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign key_valid   = !w_empty;
  assign key_code    = (w_count == '0) ? '0 : w_fifo_data;
  assign any_pressed = |r_prev;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: directed scenarios plus a randomized run against a queue-based model.
module tb_key_event_encoder;

  localparam int N  = 5;
  localparam int NK = N * N;
  localparam int KW = 5;
  localparam int FD = 4;
  localparam int RD = 250;
  localparam int RR = 50;

  logic          clk_500hz = 1'b0;
  logic          rst       = 1'b1;
  logic [NK-1:0] isPressed = '0;
  logic          key_ready = 1'b0;
  logic [KW-1:0] key_code;
  logic          key_valid;
  logic          any_pressed;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  key_event_encoder #(
    .N            (N),
    .FIFO_DEPTH   (FD),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk_500hz   (clk_500hz),
    .rst         (rst),
    .isPressed   (isPressed),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .any_pressed (any_pressed),
    .overflow    (overflow)
  );

  always #5 clk_500hz = ~clk_500hz;

  // Reference model: a queue of key indices plus a set of pending presses.
  int            m_q[$];
  bit [NK-1:0]   m_prev;
  bit [NK-1:0]   m_pend;
  bit            m_ovf;
  int            m_hold;
  bit [NK-1:0]   m_ev;
  int            m_head;

  always @(posedge clk_500hz) begin
    if (rst) begin
      m_q.delete();
      m_prev = '0;
      m_pend = '0;
      m_ovf  = 1'b0;
      m_hold = 0;
    end else begin
      m_ev = isPressed & ~m_prev;
`ifdef KEY_REPEAT_EN
      if ($countones(isPressed) == 1 && isPressed == m_prev) begin
        m_hold++;
        if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RR == 0)) m_ev |= isPressed;
      end else begin
        m_hold = 0;
      end
`endif
      if ((m_ev & m_pend) != '0) m_ovf = 1'b1;
      m_head = -1;
      for (int i = 0; i < NK; i++) begin
        if (m_pend[i]) begin
          m_head = i;
          break;
        end
      end
      if (m_q.size() > 0 && key_ready) void'(m_q.pop_front());
      m_pend = m_pend | m_ev;
      if (m_head >= 0 && m_q.size() < FD) begin
        m_q.push_back(m_head);
        m_pend[m_head] = 1'b0;
      end
      m_prev = isPressed;
    end
  end

  task automatic apply_reset();
    rst       = 1'b1;
    isPressed = '0;
    key_ready = 1'b0;
    repeat (2) @(negedge clk_500hz);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    isPressed = NK'($urandom);
    key_ready = 1'b1;
    repeat (2) @(negedge clk_500hz);
    total++;
    if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    total++;
    if (key_code !== '0) begin bad++; $display("FAIL reset_code: got %0d want 0", key_code); end
    total++;
    if (any_pressed !== 1'b0) begin bad++; $display("FAIL reset_any: got %b want 0", any_pressed); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    isPressed = '0;
    rst       = 1'b0;
  endtask

  task automatic test_single_press();
    int extra;
    apply_reset();
    key_ready = 1'b1;
    repeat (3) @(negedge clk_500hz);
    isPressed[7] = 1'b1;
    @(negedge clk_500hz);
    total++;
    if (key_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass: key_valid=%b want 0", key_valid); end
    @(negedge clk_500hz);
    total++;
    if (key_valid !== 1'b1 || key_code !== KW'(7))
      begin bad++; $display("FAIL single_event: valid=%b code=%0d want valid=1 code=7", key_valid, key_code); end
    total++;
    if (any_pressed !== 1'b1) begin bad++; $display("FAIL single_any: got %b want 1", any_pressed); end
    extra = 0;
    repeat (8) begin
      @(negedge clk_500hz);
      if (key_valid === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL single_once: extra events=%0d want 0", extra); end
    isPressed = '0;
  endtask

  task automatic test_simultaneous();
    int exp_codes[3] = '{3, 12, 20};
    apply_reset();
    key_ready = 1'b1;
    repeat (2) @(negedge clk_500hz);
    isPressed[3]  = 1'b1;
    isPressed[12] = 1'b1;
    isPressed[20] = 1'b1;
    @(negedge clk_500hz);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_500hz);
      total++;
      if (key_valid !== 1'b1 || key_code !== KW'(exp_codes[i]))
        begin bad++; $display("FAIL simul_code%0d: valid=%b code=%0d want valid=1 code=%0d", i, key_valid, key_code, exp_codes[i]); end
    end
    @(negedge clk_500hz);
    total++;
    if (key_valid !== 1'b0) begin bad++; $display("FAIL simul_drained: valid=%b want 0", key_valid); end
    isPressed = '0;
  endtask

  task automatic test_backpressure();
    int exp_codes[4] = '{2, 3, 4, 5};
    apply_reset();
    key_ready = 1'b0;
    for (int k = 1; k <= 5; k++) isPressed[k] = 1'b1;
    repeat (8) @(negedge clk_500hz);
    total++;
    if (key_valid !== 1'b1 || key_code !== KW'(1))
      begin bad++; $display("FAIL bp_head: valid=%b code=%0d want valid=1 code=1", key_valid, key_code); end
    isPressed[5] = 1'b0;
    @(negedge clk_500hz);
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL bp_no_ovf: got %b want 0", overflow); end
    isPressed[5] = 1'b1;
    @(negedge clk_500hz);
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf_set: got %b want 1", overflow); end
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_500hz);
      total++;
      if (key_valid !== 1'b1 || key_code !== KW'(exp_codes[i]))
        begin bad++; $display("FAIL bp_drain%0d: valid=%b code=%0d want valid=1 code=%0d", i, key_valid, key_code, exp_codes[i]); end
    end
    @(negedge clk_500hz);
    total++;
    if (key_valid !== 1'b0 || overflow !== 1'b1)
      begin bad++; $display("FAIL bp_end: valid=%b ovf=%b want valid=0 ovf=1", key_valid, overflow); end
    isPressed = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    key_ready = 1'b0;
    isPressed[2]  = 1'b1;
    isPressed[6]  = 1'b1;
    isPressed[9]  = 1'b1;
    isPressed[11] = 1'b1;
    isPressed[14] = 1'b1;
    repeat (8) @(negedge clk_500hz);
    isPressed[14] = 1'b0;
    @(negedge clk_500hz);
    isPressed[14] = 1'b1;
    @(negedge clk_500hz);
    total++;
    if (overflow !== 1'b1 || key_valid !== 1'b1)
      begin bad++; $display("FAIL mid_pre: ovf=%b valid=%b want ovf=1 valid=1", overflow, key_valid); end
    rst = 1'b1;
    @(negedge clk_500hz);
    total++;
    if (key_valid !== 1'b0 || overflow !== 1'b0 || any_pressed !== 1'b0)
      begin bad++; $display("FAIL mid_cleared: valid=%b ovf=%b any=%b want 0 0 0", key_valid, overflow, any_pressed); end
    rst = 1'b0;
    @(negedge clk_500hz);
    total++;
    if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_no_bypass: valid=%b want 0", key_valid); end
    @(negedge clk_500hz);
    total++;
    if (key_valid !== 1'b1 || key_code !== KW'(2))
      begin bad++; $display("FAIL mid_rereport: valid=%b code=%0d want valid=1 code=2", key_valid, key_code); end
    isPressed = '0;
  endtask

  task automatic test_repeat();
    int ev_t[$];
    int ev_c[$];
    int exp_t[$];
    int exp_c[$];
`ifdef KEY_REPEAT_EN
    exp_t = '{1, 251, 301, 351};
`else
    exp_t = '{1};
`endif
    apply_reset();
    key_ready = 1'b1;
    repeat (2) @(negedge clk_500hz);
    isPressed[0] = 1'b1;
    for (int t = 0; t <= 410; t++) begin
      @(negedge clk_500hz);
      if (key_valid === 1'b1) ev_t.push_back(t);
      if (t == 399) isPressed = '0;
    end
    total++;
    if (ev_t.size() != exp_t.size())
      begin bad++; $display("FAIL rpt_hold_count: events=%0d want %0d", ev_t.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < ev_t.size(); i++) begin
      total++;
      if (ev_t[i] != exp_t[i]) begin bad++; $display("FAIL rpt_hold_time%0d: cycle=%0d want %0d", i, ev_t[i], exp_t[i]); end
    end

`ifdef KEY_REPEAT_EN
    exp_t = '{1, 251, 281};
    exp_c = '{0, 0, 1};
`else
    exp_t = '{1, 281};
    exp_c = '{0, 1};
`endif
    ev_t.delete();
    apply_reset();
    key_ready = 1'b1;
    repeat (2) @(negedge clk_500hz);
    isPressed[0] = 1'b1;
    for (int t = 0; t <= 450; t++) begin
      @(negedge clk_500hz);
      if (key_valid === 1'b1) begin
        ev_t.push_back(t);
        ev_c.push_back(int'(key_code));
      end
      if (t == 279) isPressed[1] = 1'b1;
    end
    total++;
    if (ev_t.size() != exp_t.size())
      begin bad++; $display("FAIL rpt_second_count: events=%0d want %0d", ev_t.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < ev_t.size(); i++) begin
      total++;
      if (ev_t[i] != exp_t[i] || ev_c[i] != exp_c[i])
        begin bad++; $display("FAIL rpt_second_ev%0d: cycle=%0d code=%0d want cycle=%0d code=%0d", i, ev_t[i], ev_c[i], exp_t[i], exp_c[i]); end
    end
    isPressed = '0;
  endtask

  task automatic test_random();
    bit          exp_valid;
    bit [KW-1:0] exp_code;
    int          k;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_500hz);
      exp_valid = (m_q.size() > 0);
      exp_code  = exp_valid ? KW'(m_q[0]) : '0;
      total++;
      if (key_valid !== exp_valid) begin bad++; $display("FAIL rand_valid @%0d: got %b want %b", cyc, key_valid, exp_valid); end
      total++;
      if (key_code !== exp_code) begin bad++; $display("FAIL rand_code @%0d: got %0d want %0d", cyc, key_code, exp_code); end
      total++;
      if (any_pressed !== (|m_prev)) begin bad++; $display("FAIL rand_any @%0d: got %b want %b", cyc, any_pressed, |m_prev); end
      total++;
      if (overflow !== m_ovf) begin bad++; $display("FAIL rand_ovf @%0d: got %b want %b", cyc, overflow, m_ovf); end
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, NK - 1);
        isPressed[k] = ~isPressed[k];
      end
      if ($countones(isPressed) > 3) isPressed = '0;
      key_ready = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    isPressed = '0;
  endtask

  initial begin
    @(negedge clk_500hz);
    test_reset();
    test_single_press();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
